// File: rtl/ibex_pkg.sv
// Shared types for the FP result arbiter: buffered result entry and flag width.
package ibex_pkg;

  localparam int unsigned FFLAGS_W  = 5;
  localparam int unsigned FP_DATA_W = 32;

  typedef struct packed {
    logic [4:0]          waddr;
    logic [31:0]         data;
    logic [FFLAGS_W-1:0] fflags;
  } fp_res_t;

  localparam int unsigned FP_RES_Q_W = FP_DATA_W + FFLAGS_W;

endpackage

// File: rtl/ibex_fp_res_fifo.sv
// Generic Depth-entry synchronous FIFO; exposes its read pointer so a
// companion queue can be read in lockstep.
module ibex_fp_res_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o,
  output logic [PtrW-1:0]  rd_ptr_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (pop_i) begin
      rptr_d = ptr_inc(rptr_q);
    end
    cnt_d = cnt_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rdata_o  = mem_q[rptr_q];
  assign full_o   = (cnt_q == CntW'(Depth));
  assign empty_o  = (cnt_q == '0);
  assign count_o  = cnt_q;
  assign rd_ptr_o = rptr_q;

endmodule

// File: rtl/ibex_fp_result_arbiter.sv
// Buffers multi-cycle FPU results in issue order and injects them into the
// writeback FRF port when ID/EX and the LSU leave it idle.
module ibex_fp_result_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned Depth       = 2,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  input  logic [4:0]          issue_waddr_i,
  output logic                issue_ready_o,
  input  logic                fpu_res_valid_i,
  input  logic [31:0]         fpu_res_data_i,
  input  logic [FFLAGS_W-1:0] fpu_res_fflags_i,
  input  logic                id_we_i,
  input  logic                lsu_we_i,
  output logic                wb_frf_we_o,
  output logic [4:0]          wb_waddr_o,
  output logic [31:0]         wb_wdata_o,
  output logic                fflags_we_o,
  output logic [FFLAGS_W-1:0] fflags_o,
  output logic [31:0]         pending_o,
  output logic                stall_id_we_o,
  output logic                busy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned StW  = $clog2(StarveLimit + 1);

  logic [4:0]      tag_q [Depth];
  logic [4:0]      tag_d [Depth];
  logic [PtrW-1:0] tag_wptr_q, tag_wptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     pending_q, pending_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic            flush_q;

  logic                  issue_fire;
  logic                  head_ready;
  logic                  drain;
  logic                  res_push;
  logic [FP_RES_Q_W-1:0] res_rdata;
  logic                  res_full;
  logic                  res_empty;
  logic [CntW-1:0]       res_count;
  logic [PtrW-1:0]       rd_ptr;
  fp_res_t               head;

  // Results landing the cycle after reset belong to discarded ops.
  assign res_push = fpu_res_valid_i & ~flush_q;

  // The result FIFO's read pointer doubles as the tag queue read pointer.
  ibex_fp_res_fifo #(
    .Width (FP_RES_Q_W),
    .Depth (Depth)
  ) u_res_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (res_push),
    .wdata_i  ({fpu_res_data_i, fpu_res_fflags_i}),
    .pop_i    (drain),
    .rdata_o  (res_rdata),
    .full_o   (res_full),
    .empty_o  (res_empty),
    .count_o  (res_count),
    .rd_ptr_o (rd_ptr)
  );

  always_comb begin
    issue_ready_o = (cnt_q < CntW'(Depth));
    issue_fire    = issue_valid_i & issue_ready_o;
    head_ready    = ~res_empty;
    drain         = head_ready & ~id_we_i & ~lsu_we_i;

    head.waddr  = tag_q[rd_ptr];
    head.data   = res_rdata[FFLAGS_W +: FP_DATA_W];
    head.fflags = res_rdata[FFLAGS_W-1:0];

    wb_frf_we_o = drain;
    fflags_we_o = drain;
    wb_waddr_o  = drain ? head.waddr  : '0;
    wb_wdata_o  = drain ? head.data   : '0;
    fflags_o    = drain ? head.fflags : '0;
  end

  always_comb begin
    tag_d      = tag_q;
    tag_wptr_d = tag_wptr_q;
    pending_d  = pending_q;
    starve_d   = starve_q;
    cnt_d      = cnt_q + CntW'(issue_fire) - CntW'(drain);

    // Clear before set so a same-cycle re-issue of the draining register wins.
    if (drain) begin
      pending_d[head.waddr] = 1'b0;
    end
    if (issue_fire) begin
      pending_d[issue_waddr_i] = 1'b1;
      tag_d[tag_wptr_q]        = issue_waddr_i;
      tag_wptr_d = (tag_wptr_q == PtrW'(Depth - 1)) ? '0 : tag_wptr_q + 1'b1;
    end

    if (drain || !head_ready) begin
      starve_d = '0;
    end else if (starve_q < StW'(StarveLimit)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        tag_q[i] <= '0;
      end
      tag_wptr_q <= '0;
      cnt_q      <= '0;
      pending_q  <= '0;
      starve_q   <= '0;
      flush_q    <= 1'b1;
    end else begin
      tag_q      <= tag_d;
      tag_wptr_q <= tag_wptr_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      starve_q   <= starve_d;
      flush_q    <= 1'b0;
    end
  end

  assign pending_o     = pending_q;
  assign busy_o        = (cnt_q != '0);
  assign stall_id_we_o = (starve_q >= StW'(StarveLimit));

  a_issue_not_pending: assert property (@(posedge clk_i) disable iff (rst_i)
    issue_fire |-> (!pending_q[issue_waddr_i] || (drain && head.waddr == issue_waddr_i)));

  a_result_has_tag: assert property (@(posedge clk_i) disable iff (rst_i)
    res_push |-> (res_count < cnt_q) && (!res_full || drain));

endmodule

// File: tb/tb_ibex_fp_result_arbiter.sv
// Bench for ibex_fp_result_arbiter: directed scenarios then random traffic,
// all checked against an in-order queue model of outstanding ops.
module tb_ibex_fp_result_arbiter;

  localparam int DEPTH = 2;
  localparam int SL    = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic [4:0]  issue_waddr_i;
  logic        issue_ready_o;
  logic        fpu_res_valid_i;
  logic [31:0] fpu_res_data_i;
  logic [4:0]  fpu_res_fflags_i;
  logic        id_we_i;
  logic        lsu_we_i;
  logic        wb_frf_we_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;
  logic        fflags_we_o;
  logic [4:0]  fflags_o;
  logic [31:0] pending_o;
  logic        stall_id_we_o;
  logic        busy_o;

  ibex_fp_result_arbiter #(
    .Depth       (DEPTH),
    .StarveLimit (SL)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .issue_valid_i    (issue_valid_i),
    .issue_waddr_i    (issue_waddr_i),
    .issue_ready_o    (issue_ready_o),
    .fpu_res_valid_i  (fpu_res_valid_i),
    .fpu_res_data_i   (fpu_res_data_i),
    .fpu_res_fflags_i (fpu_res_fflags_i),
    .id_we_i          (id_we_i),
    .lsu_we_i         (lsu_we_i),
    .wb_frf_we_o      (wb_frf_we_o),
    .wb_waddr_o       (wb_waddr_o),
    .wb_wdata_o       (wb_wdata_o),
    .fflags_we_o      (fflags_we_o),
    .fflags_o         (fflags_o),
    .pending_o        (pending_o),
    .stall_id_we_o    (stall_id_we_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  waddr;
    bit          has_res;
    logic [31:0] data;
    logic [4:0]  flags;
  } op_t;

  op_t mq[$];
  int  starve;
  bit  mflush;
  int  tests;
  int  fails;

  logic        obs_ready, obs_we, obs_fwe, obs_stall, obs_busy;
  logic [4:0]  obs_waddr, obs_flags;
  logic [31:0] obs_wdata, obs_pend;

  function automatic logic [31:0] m_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i].waddr] = 1'b1;
    return p;
  endfunction

  function automatic int m_unresolved();
    int n = 0;
    foreach (mq[i]) if (!mq[i].has_res) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic cyc(input bit r, input bit iv, input logic [4:0] wa,
                     input bit rv, input logic [31:0] rd, input logic [4:0] rf,
                     input bit id, input bit lsu);
    bit          e_ready, hr, e_we;
    logic [4:0]  e_waddr, e_flags;
    logic [31:0] e_data;
    bit          found;
    rst_i = r; issue_valid_i = iv; issue_waddr_i = wa;
    fpu_res_valid_i = rv; fpu_res_data_i = rd; fpu_res_fflags_i = rf;
    id_we_i = id; lsu_we_i = lsu;
    #4;
    e_ready = (mq.size() < DEPTH);
    hr      = (mq.size() > 0) && mq[0].has_res;
    e_we    = hr && !id && !lsu;
    e_waddr = e_we ? mq[0].waddr : 5'd0;
    e_data  = e_we ? mq[0].data  : 32'd0;
    e_flags = e_we ? mq[0].flags : 5'd0;
    obs_ready = issue_ready_o; obs_we = wb_frf_we_o; obs_fwe = fflags_we_o;
    obs_stall = stall_id_we_o; obs_busy = busy_o; obs_waddr = wb_waddr_o;
    obs_flags = fflags_o; obs_wdata = wb_wdata_o; obs_pend = pending_o;
    chk("issue_ready", {31'd0, obs_ready}, {31'd0, e_ready});
    chk("wb_frf_we",   {31'd0, obs_we},    {31'd0, e_we});
    chk("fflags_we",   {31'd0, obs_fwe},   {31'd0, e_we});
    chk("wb_waddr",    {27'd0, obs_waddr}, {27'd0, e_waddr});
    chk("wb_wdata",    obs_wdata,          e_data);
    chk("fflags",      {27'd0, obs_flags}, {27'd0, e_flags});
    chk("pending",     obs_pend,           m_pending());
    chk("stall_id_we", {31'd0, obs_stall}, {31'd0, starve >= SL});
    chk("busy",        {31'd0, obs_busy},  {31'd0, mq.size() != 0});
    @(posedge clk);
    if (r) begin
      mq.delete();
      starve = 0;
      mflush = 1'b1;
    end else begin
      if (e_we) void'(mq.pop_front());
      if (rv && !mflush) begin
        found = 1'b0;
        foreach (mq[i]) begin
          if (!found && !mq[i].has_res) begin
            mq[i].has_res = 1'b1; mq[i].data = rd; mq[i].flags = rf;
            found = 1'b1;
          end
        end
      end
      if (iv && e_ready) mq.push_back('{waddr: wa, has_res: 1'b0, data: 32'd0, flags: 5'd0});
      if (e_we || !hr) starve = 0;
      else if (starve < SL) starve++;
      mflush = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 5'd0, 0, 32'd0, 5'd0, 0, 0);
  endtask

  initial begin
    bit          r, iv, rv, id, lsu;
    logic [4:0]  wa;
    logic [31:0] pend;
    tests = 0; fails = 0; starve = 0;
    rst_i = 1'b1; issue_valid_i = 1'b0; issue_waddr_i = '0;
    fpu_res_valid_i = 1'b0; fpu_res_data_i = '0; fpu_res_fflags_i = '0;
    id_we_i = 1'b0; lsu_we_i = 1'b0;
    @(posedge clk);
    mflush = 1'b1;
    #1;

    // Reset state
    idle();
    chk("rst_ready", {31'd0, obs_ready}, 32'd1);
    chk("rst_pend",  obs_pend, 32'd0);
    chk("rst_busy",  {31'd0, obs_busy}, 32'd0);
    chk("rst_wdata", obs_wdata, 32'd0);

    // Single op on f5
    cyc(0, 1, 5'd5, 0, 32'd0, 5'd0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      idle();
      chk("t1_pend5", {31'd0, obs_pend[5]}, 32'd1);
    end
    cyc(0, 0, 5'd0, 1, 32'h3F80_0000, 5'h01, 0, 0);
    chk("t1_no_early_we", {31'd0, obs_we}, 32'd0);
    idle();
    chk("t1_we",    {31'd0, obs_we}, 32'd1);
    chk("t1_waddr", {27'd0, obs_waddr}, 32'd5);
    chk("t1_wdata", obs_wdata, 32'h3F80_0000);
    chk("t1_flags", {27'd0, obs_flags}, 32'h1);
    idle();
    chk("t1_pend_clr", obs_pend, 32'd0);

    // Full: f1, f2 then f3 refused
    cyc(0, 1, 5'd1, 0, 32'd0, 5'd0, 0, 0);
    cyc(0, 1, 5'd2, 0, 32'd0, 5'd0, 0, 0);
    chk("t2_ready_before_full", {31'd0, obs_ready}, 32'd1);
    cyc(0, 1, 5'd3, 0, 32'd0, 5'd0, 0, 0);
    chk("t2_not_ready", {31'd0, obs_ready}, 32'd0);
    cyc(0, 0, 5'd0, 1, 32'hAAAA_0001, 5'h02, 0, 0);
    chk("t2_f3_ignored", {31'd0, obs_pend[3]}, 32'd0);
    cyc(0, 0, 5'd0, 1, 32'hBBBB_0002, 5'h04, 0, 0);
    chk("t2_first_waddr", {27'd0, obs_waddr}, 32'd1);
    idle();
    chk("t2_ready_again", {31'd0, obs_ready}, 32'd1);
    chk("t2_second_waddr", {27'd0, obs_waddr}, 32'd2);
    chk("t2_second_wdata", obs_wdata, 32'hBBBB_0002);
    idle();

    // Port conflict with ID/EX until starvation stall
    cyc(0, 1, 5'd9, 0, 32'd0, 5'd0, 0, 0);
    idle();
    cyc(0, 0, 5'd0, 1, 32'hC0DE_0009, 5'h08, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 5'd0, 0, 32'd0, 5'd0, 1, 0);
      chk("t3_blocked", {31'd0, obs_we}, 32'd0);
      chk("t3_no_stall", {31'd0, obs_stall}, 32'd0);
    end
    idle();
    chk("t3_stall", {31'd0, obs_stall}, 32'd1);
    chk("t3_drain", {31'd0, obs_we}, 32'd1);
    chk("t3_waddr", {27'd0, obs_waddr}, 32'd9);
    idle();
    chk("t3_stall_clr", {31'd0, obs_stall}, 32'd0);

    // LSU holds the port for two cycles
    cyc(0, 1, 5'd12, 0, 32'd0, 5'd0, 0, 0);
    cyc(0, 0, 5'd0, 1, 32'h1234_5678, 5'h10, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 5'd0, 0, 32'd0, 5'd0, 0, 1);
      chk("t4_lsu_blocks", {31'd0, obs_we}, 32'd0);
    end
    idle();
    chk("t4_we", {31'd0, obs_we}, 32'd1);
    chk("t4_waddr", {27'd0, obs_waddr}, 32'd12);

    // Drain f7 while re-issuing f7
    cyc(0, 1, 5'd7, 0, 32'd0, 5'd0, 0, 0);
    cyc(0, 0, 5'd0, 1, 32'hD000_0007, 5'h00, 0, 0);
    cyc(0, 1, 5'd7, 0, 32'd0, 5'd0, 0, 0);
    chk("t5_drain_we", {31'd0, obs_we}, 32'd1);
    chk("t5_drain_waddr", {27'd0, obs_waddr}, 32'd7);
    idle();
    chk("t5_pend7", {31'd0, obs_pend[7]}, 32'd1);
    chk("t5_busy", {31'd0, obs_busy}, 32'd1);
    chk("t5_ready", {31'd0, obs_ready}, 32'd1);
    cyc(0, 0, 5'd0, 1, 32'hE000_0007, 5'h03, 0, 0);
    idle();
    chk("t5_second_wdata", obs_wdata, 32'hE000_0007);
    idle();

    // Reset with work in flight
    cyc(0, 1, 5'd3, 0, 32'd0, 5'd0, 0, 0);
    cyc(0, 1, 5'd4, 0, 32'd0, 5'd0, 0, 0);
    cyc(0, 0, 5'd0, 1, 32'hF000_0003, 5'h01, 0, 1);
    cyc(1, 0, 5'd0, 0, 32'd0, 5'd0, 0, 1);
    cyc(0, 0, 5'd0, 1, 32'hF000_0004, 5'h02, 0, 0);
    chk("t6_pend", obs_pend, 32'd0);
    chk("t6_busy", {31'd0, obs_busy}, 32'd0);
    chk("t6_ready", {31'd0, obs_ready}, 32'd1);
    idle();
    chk("t6_late_ignored", {31'd0, obs_we}, 32'd0);

    // Random legal traffic
    for (int n = 0; n < 3000; n++) begin
      r    = ($urandom_range(199) == 0);
      pend = m_pending();
      iv   = ($urandom_range(2) == 0);
      wa   = 5'($urandom_range(31));
      for (int k = 0; k < 8 && pend[wa]; k++) wa = 5'($urandom_range(31));
      if (pend[wa]) iv = 1'b0;
      rv   = (m_unresolved() > 0) && !mflush && ($urandom_range(2) == 0);
      id   = (starve >= SL) ? ($urandom_range(7) == 0) : ($urandom_range(1) == 0);
      lsu  = ($urandom_range(3) == 0);
      cyc(r, iv, wa, rv, $urandom, 5'($urandom_range(31)), id, lsu);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
